// File: rtl/adxl345_sequencer.sv
// ============================================================================
//  Module   : adxl345_sequencer
//  Purpose  : Drives a byte-level I2C engine to configure the ADXL345
//             accelerometer (DATA_FORMAT, BW_RATE, POWER_CTL), then reads the
//             six axis data registers once per sample period. Every WRITE is
//             ACK-checked; a NACK aborts with STOP and the transaction is
//             retried up to MAX_RETRY times before the block locks in FAULT.
//  Ports    : CLOCK_50        system clock (rising edge)
//             reset           synchronous, active-low
//             cmd_valid/ready op handshake to the I2C engine
//             cmd_op/cmd_data 0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP
//             rsp_valid/data/nack  completion pulse, read byte, write NACK
//             accel_x/y/z     last sample (two's complement)
//             sample_valid    one-cycle pulse when accel_* update
//             busy, overrun, fault, state_dbg  status for HEX display
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adxl345_sequencer #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         SAMPLE_HZ = 100,
  parameter logic [6:0] DEV_ADDR  = 7'h53,
  parameter int         MAX_RETRY = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        fault,
  output logic [3:0]  state_dbg
);

  localparam logic [2:0]  c_OP_START     = 3'd0;
  localparam logic [2:0]  c_OP_WRITE     = 3'd1;
  localparam logic [2:0]  c_OP_READ_ACK  = 3'd2;
  localparam logic [2:0]  c_OP_READ_NACK = 3'd3;
  localparam logic [2:0]  c_OP_STOP      = 3'd4;

  localparam logic [2:0]  c_ST_CFG   = 3'd0;
  localparam logic [2:0]  c_ST_IDLE  = 3'd1;
  localparam logic [2:0]  c_ST_RD    = 3'd2;
  localparam logic [2:0]  c_ST_ABORT = 3'd3;
  localparam logic [2:0]  c_ST_FAULT = 3'd4;

  localparam logic [31:0] c_SAMPLE_PERIOD = 32'(CLK_HZ / SAMPLE_HZ);
  localparam logic [7:0]  c_WR_ADDR       = {DEV_ADDR, 1'b0};
  localparam logic [7:0]  c_RD_ADDR       = {DEV_ADDR, 1'b1};
  localparam logic [7:0]  c_MAX_RETRY     = 8'(MAX_RETRY);
  localparam logic [7:0]  c_REG_DATAX0    = 8'h32;

  logic [2:0]  r_state;
  logic [2:0]  r_resume;      // transaction to restart after an ABORT STOP
  logic [3:0]  r_step;        // op index inside the current transaction
  logic [1:0]  r_cfg_idx;
  logic [7:0]  r_retry;
  logic [31:0] r_timer;
  logic        r_pending;
  logic        r_outstanding;
  logic [47:0] r_rx;          // bytes shift in from the top: {Z1,Z0,Y1,Y0,X1,X0}

  logic        w_tick;
  logic        w_pend_clr;
  logic [2:0]  w_op;
  logic [7:0]  w_data;
  logic [7:0]  w_cfg_reg;
  logic [7:0]  w_cfg_val;

  assign w_tick     = (r_timer == c_SAMPLE_PERIOD - 32'd1);
  assign w_pend_clr = (r_state == c_ST_IDLE) && r_pending;

  always_comb begin
    case (r_cfg_idx)
      2'd0:    begin w_cfg_reg = 8'h31; w_cfg_val = 8'h0B; end
      2'd1:    begin w_cfg_reg = 8'h2C; w_cfg_val = 8'h0B; end
      default: begin w_cfg_reg = 8'h2D; w_cfg_val = 8'h08; end
    endcase
  end

  // Next op to offer, derived from the transaction position.
  always_comb begin
    w_op   = c_OP_STOP;
    w_data = 8'h00;
    case (r_state)
      c_ST_CFG: begin
        case (r_step)
          4'd0:    w_op = c_OP_START;
          4'd1:    begin w_op = c_OP_WRITE; w_data = c_WR_ADDR; end
          4'd2:    begin w_op = c_OP_WRITE; w_data = w_cfg_reg; end
          4'd3:    begin w_op = c_OP_WRITE; w_data = w_cfg_val; end
          default: w_op = c_OP_STOP;
        endcase
      end
      c_ST_RD: begin
        case (r_step)
          4'd0, 4'd3:                   w_op = c_OP_START;
          4'd1:    begin w_op = c_OP_WRITE; w_data = c_WR_ADDR;    end
          4'd2:    begin w_op = c_OP_WRITE; w_data = c_REG_DATAX0; end
          4'd4:    begin w_op = c_OP_WRITE; w_data = c_RD_ADDR;    end
          4'd5, 4'd6, 4'd7, 4'd8, 4'd9: w_op = c_OP_READ_ACK;
          4'd10:                        w_op = c_OP_READ_NACK;
          default:                      w_op = c_OP_STOP;
        endcase
      end
      default: w_op = c_OP_STOP;
    endcase
  end

  always_comb begin
    case (r_state)
      c_ST_CFG:   state_dbg = 4'd1;
      c_ST_IDLE:  state_dbg = 4'd2;
      c_ST_RD:    state_dbg = 4'd3;
      c_ST_ABORT: state_dbg = 4'd4;
      default:    state_dbg = 4'd15;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      cmd_valid     <= 1'b0;
      cmd_op        <= 3'd0;
      cmd_data      <= 8'h00;
      accel_x       <= 16'h0000;
      accel_y       <= 16'h0000;
      accel_z       <= 16'h0000;
      sample_valid  <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      fault         <= 1'b0;
      r_state       <= c_ST_CFG;
      r_resume      <= c_ST_CFG;
      r_step        <= 4'd0;
      r_cfg_idx     <= 2'd0;
      r_retry       <= 8'd0;
      r_timer       <= 32'd0;
      r_pending     <= 1'b0;
      r_outstanding <= 1'b0;
      r_rx          <= 48'd0;
    end else begin
      sample_valid <= 1'b0;
      r_timer      <= w_tick ? 32'd0 : r_timer + 32'd1;
      // A tick landing on the clear cycle still leaves a request pending.
      r_pending    <= w_tick | (r_pending & ~w_pend_clr);
      if (w_tick && r_pending)
        overrun <= 1'b1;

      case (r_state)
        c_ST_IDLE: begin
          if (r_pending) begin
            r_state <= c_ST_RD;
            r_step  <= 4'd0;
          end
        end
        c_ST_FAULT: ;
        default: begin
          if (cmd_valid) begin
            if (cmd_ready) begin
              cmd_valid     <= 1'b0;
              r_outstanding <= 1'b1;
              busy          <= 1'b1;
            end
          end else if (r_outstanding) begin
            if (rsp_valid) begin
              r_outstanding <= 1'b0;
              if (cmd_op == c_OP_WRITE && rsp_nack) begin
                r_resume <= r_state;
                r_state  <= c_ST_ABORT;
              end else if (cmd_op == c_OP_STOP) begin
                case (r_state)
                  c_ST_ABORT: begin
                    if (r_retry < c_MAX_RETRY) begin
                      r_retry <= r_retry + 8'd1;
                      r_state <= r_resume;
                      r_step  <= 4'd0;
                    end else begin
                      fault   <= 1'b1;
                      busy    <= 1'b0;
                      r_state <= c_ST_FAULT;
                    end
                  end
                  c_ST_RD: begin
                    accel_x      <= r_rx[15:0];
                    accel_y      <= r_rx[31:16];
                    accel_z      <= r_rx[47:32];
                    sample_valid <= 1'b1;
                    r_retry      <= 8'd0;
                    busy         <= 1'b0;
                    r_state      <= c_ST_IDLE;
                  end
                  default: begin
                    r_retry <= 8'd0;
                    r_step  <= 4'd0;
                    if (r_cfg_idx == 2'd2) begin
                      busy    <= 1'b0;
                      r_state <= c_ST_IDLE;
                    end else begin
                      r_cfg_idx <= r_cfg_idx + 2'd1;
                    end
                  end
                endcase
              end else begin
                if (cmd_op == c_OP_READ_ACK || cmd_op == c_OP_READ_NACK)
                  r_rx <= {rsp_data, r_rx[47:8]};
                r_step <= r_step + 4'd1;
              end
            end
          end else begin
            cmd_valid <= 1'b1;
            cmd_op    <= w_op;
            cmd_data  <= w_data;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adxl345_sequencer.sv
// ============================================================================
//  Module   : tb_adxl345_sequencer
//  Purpose  : Self-checking bench for adxl345_sequencer. A behavioural I2C
//             engine accepts ops, logs them and answers after two cycles
//             with scripted read bytes and NACKs; logged op streams are
//             compared against expected op tables.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adxl345_sequencer;

  localparam logic [2:0] c_START = 3'd0;
  localparam logic [2:0] c_WRITE = 3'd1;
  localparam logic [2:0] c_RACK  = 3'd2;
  localparam logic [2:0] c_RNACK = 3'd3;
  localparam logic [2:0] c_STOP  = 3'd4;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] rsp;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
  } log_t;

  logic        CLOCK_50;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_nack;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, busy, overrun, fault;
  logic [3:0]  state_dbg;

  adxl345_sequencer #(
    .CLK_HZ    (1000),
    .SAMPLE_HZ (10),
    .DEV_ADDR  (7'h53),
    .MAX_RETRY (3)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_nack     (rsp_nack),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .accel_z      (accel_z),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .fault        (fault),
    .state_dbg    (state_dbg)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int          n_vec = 0;
  int          n_err = 0;
  vec_t        exp_q[$];
  log_t        log_q[$];
  logic [7:0]  rd_bytes[6];
  int          nack_mode = 0;     // 0 none, 1 first WRITE 0x2C once, 2 every WRITE 0xA6
  bit          nack_used = 1'b0;
  int          stall_left = 0;
  logic [10:0] stall_exp = 11'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural I2C engine: all activity on the falling edge.
  initial begin : engine
    int         cnt;
    int         rd_idx;
    logic [7:0] pend_data;
    logic       pend_nack;
    cnt = 0; rd_idx = 0; pend_data = 8'h00; pend_nack = 1'b0;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 8'h00; rsp_nack = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      rsp_valid = 1'b0; rsp_data = 8'h00; rsp_nack = 1'b0;
      if (!reset) begin
        cnt = 0; rd_idx = 0; cmd_ready = 1'b1;
        continue;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rsp_valid = 1'b1; rsp_data = pend_data; rsp_nack = pend_nack;
        end
      end
      if (cmd_valid && cmd_op == c_WRITE && stall_left > 0) begin
        chk("stall_hold", {20'd0, cmd_valid, cmd_op, cmd_data}, {20'd0, 1'b1, stall_exp});
        cmd_ready = 1'b0;
        stall_left--;
      end else begin
        cmd_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        log_q.push_back('{op: cmd_op, data: cmd_data});
        pend_data = 8'h00;
        pend_nack = 1'b0;
        if (cmd_op == c_RACK || cmd_op == c_RNACK) begin
          pend_data = rd_bytes[rd_idx];
          rd_idx    = (rd_idx + 1) % 6;
        end
        if (cmd_op == c_WRITE) begin
          if (nack_mode == 2 && cmd_data == 8'hA6) pend_nack = 1'b1;
          if (nack_mode == 1 && cmd_data == 8'h2C && !nack_used) begin
            pend_nack = 1'b1;
            nack_used = 1'b1;
          end
        end
        cnt = 2;
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [7:0] data, input logic [7:0] rsp);
    exp_q.push_back('{op: op, data: data, rsp: rsp});
  endtask

  task automatic push_cfg(input logic [7:0] rg, input logic [7:0] val);
    push(c_START, 8'h00, 8'h00); push(c_WRITE, 8'hA6, 8'h00);
    push(c_WRITE, rg, 8'h00);    push(c_WRITE, val, 8'h00);
    push(c_STOP, 8'h00, 8'h00);
  endtask

  task automatic push_rd();
    push(c_START, 8'h00, 8'h00); push(c_WRITE, 8'hA6, 8'h00);
    push(c_WRITE, 8'h32, 8'h00); push(c_START, 8'h00, 8'h00);
    push(c_WRITE, 8'hA7, 8'h00);
    push(c_RACK, 8'h00, 8'h34);  push(c_RACK, 8'h00, 8'h12);
    push(c_RACK, 8'h00, 8'hCD);  push(c_RACK, 8'h00, 8'hAB);
    push(c_RACK, 8'h00, 8'h01);  push(c_RNACK, 8'h00, 8'h80);
    push(c_STOP, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) rd_bytes[i] = exp_q[5 + i].rsp;
  endtask

  task automatic cmp_log(input int base, input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size())
        chk($sformatf("%s[%0d]", tag, i),
            {21'd0, log_q[base + i].op, log_q[base + i].data},
            {21'd0, exp_q[i].op, exp_q[i].data});
      else
        chk($sformatf("%s[%0d]_missing", tag, i), 32'hFFFF_FFFF,
            {21'd0, exp_q[i].op, exp_q[i].data});
    end
  endtask

  task automatic wait_dbg(input logic [3:0] code, input int max, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge CLOCK_50);
      if (state_dbg == code) found = 1'b1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_sample(input int max, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge CLOCK_50);
      if (sample_valid) found = 1'b1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    chk({tag, "_cmd_op"},    {29'd0, cmd_op},    32'd0);
    chk({tag, "_cmd_data"},  {24'd0, cmd_data},  32'd0);
    chk({tag, "_accel"},     {accel_x, accel_y}, 32'd0);
    chk({tag, "_accel_z"},   {16'd0, accel_z},   32'd0);
    chk({tag, "_flags"},     {28'd0, sample_valid, busy, overrun, fault}, 32'd0);
    chk({tag, "_state"},     {28'd0, state_dbg}, 32'd1);
  endtask

  initial begin : main
    int cv;
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk_reset("rst0");
    log_q.delete();
    reset = 1'b1;

    // Configuration, every byte ACKed.
    exp_q.delete();
    push_cfg(8'h31, 8'h0B); push_cfg(8'h2C, 8'h0B); push_cfg(8'h2D, 8'h08);
    wait_dbg(4'd2, 300, "cfg_done");
    cmp_log(0, "cfg");
    chk("cfg_busy", {30'd0, busy, fault}, 32'd0);

    // First read burst.
    exp_q.delete();
    push_rd();
    wait_sample(400, "rd_sample");
    chk("rd_x", {16'd0, accel_x}, 32'h1234);
    chk("rd_y", {16'd0, accel_y}, 32'hABCD);
    chk("rd_z", {16'd0, accel_z}, 32'h8001);
    chk("rd_overrun", {31'd0, overrun}, 32'd0);
    cmp_log(15, "rd");
    chk("rd_len", 32'(log_q.size()), 32'd27);
    @(negedge CLOCK_50);
    chk("rd_pulse", {31'd0, sample_valid}, 32'd0);
    chk("rd_idle", {28'd0, state_dbg}, 32'd2);

    // Reset in the middle of the next burst.
    wait_dbg(4'd3, 300, "rd2_start");
    repeat (10) @(negedge CLOCK_50);
    reset = 1'b0;
    nack_mode = 1; nack_used = 1'b0;
    @(negedge CLOCK_50);
    chk_reset("rst_mid");
    log_q.delete();
    @(negedge CLOCK_50);
    reset = 1'b1;

    // BW_RATE register byte NACKed once: abort, retry the whole transaction.
    exp_q.delete();
    push_cfg(8'h31, 8'h0B);
    push(c_START, 8'h00, 8'h00); push(c_WRITE, 8'hA6, 8'h00);
    push(c_WRITE, 8'h2C, 8'h00); push(c_STOP, 8'h00, 8'h00);
    push_cfg(8'h2C, 8'h0B); push_cfg(8'h2D, 8'h08);
    wait_dbg(4'd2, 400, "nack_done");
    cmp_log(0, "nack");
    chk("nack_len", 32'(log_q.size()), 32'd19);
    chk("nack_fault", {31'd0, fault}, 32'd0);

    // Device address always NACKed: four attempts, then FAULT.
    reset = 1'b0; nack_mode = 2;
    repeat (2) @(negedge CLOCK_50);
    log_q.delete();
    reset = 1'b1;
    exp_q.delete();
    for (int a = 0; a < 4; a++) begin
      push(c_START, 8'h00, 8'h00); push(c_WRITE, 8'hA6, 8'h00); push(c_STOP, 8'h00, 8'h00);
    end
    wait_dbg(4'd15, 600, "fault_state");
    cmp_log(0, "fault");
    chk("fault_flag", {30'd0, fault, busy}, 32'd2);
    cv = 0;
    repeat (300) begin
      @(negedge CLOCK_50);
      if (cmd_valid) cv++;
    end
    chk("fault_quiet", 32'(cv), 32'd0);
    chk("fault_len", 32'(log_q.size()), 32'd12);
    chk("fault_overrun", {31'd0, overrun}, 32'd1);

    // cmd_ready stalls: 20 cycles on the first config WRITE, then a long
    // stall inside a burst so two sample ticks land before it finishes.
    reset = 1'b0; nack_mode = 0;
    stall_exp = {c_WRITE, 8'hA6};
    stall_left = 20;
    repeat (2) @(negedge CLOCK_50);
    log_q.delete();
    reset = 1'b1;
    exp_q.delete();
    push_cfg(8'h31, 8'h0B); push_cfg(8'h2C, 8'h0B); push_cfg(8'h2D, 8'h08);
    wait_dbg(4'd2, 400, "stall_cfg_done");
    cmp_log(0, "stall_cfg");
    chk("stall_used", 32'(stall_left), 32'd0);
    chk("stall_overrun0", {31'd0, overrun}, 32'd0);
    stall_left = 250;
    repeat (60) @(negedge CLOCK_50);
    chk("stall_busy", {27'd0, busy, state_dbg}, {27'd0, 1'b1, 4'd3});
    exp_q.delete();
    push_rd();
    wait_sample(800, "ovr_sample");
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_x", {16'd0, accel_x}, 32'h1234);
    cmp_log(15, "ovr_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
